alarm_ctrl: RTL and testbench

- Alarm stage directly downstream of the watch counter.
- Consumes the watch's current-time BCD digits and its one-second tick `tim_over`.
- Holds a user-programmed alarm time and runs an arm/ring/snooze state machine.
- Drives a square-wave buzzer and status flags for the board LEDs.

---
 rtl/alarm_if.sv | 46 ++++
 rtl/alarm_ctrl.sv | 157 +++++++++++++++
 tb/tb_alarm_ctrl.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alarm_if.sv
// Alarm controller signal bundle.
// Groups everything between the alarm stage and its neighbours: the watch
// time digits and one-second tick, the user set/arm/stop/snooze pulses, and
// the stored alarm digits, status flags and buzzer going back out.
//   master : drives time, tick and user pulses; observes alarm outputs
//   slave  : the alarm controller itself
interface alarm_if;
  logic       tim_over;
  logic [3:0] hourdec_now;
  logic [3:0] hourone_now;
  logic [3:0] mindec_now;
  logic [3:0] minone_now;
  logic       set_valid;
  logic [3:0] hourdec_set;
  logic [3:0] hourone_set;
  logic [3:0] mindec_set;
  logic [3:0] minone_set;
  logic       arm_toggle;
  logic       stop;
  logic       snooze;
  logic       set_err;
  logic [3:0] alarm_hourdec;
  logic [3:0] alarm_hourone;
  logic [3:0] alarm_mindec;
  logic [3:0] alarm_minone;
  logic       armed;
  logic       ringing;
  logic       snoozing;
  logic       buzzer;

  modport slave (
    input  tim_over, hourdec_now, hourone_now, mindec_now, minone_now,
    input  set_valid, hourdec_set, hourone_set, mindec_set, minone_set,
    input  arm_toggle, stop, snooze,
    output set_err, alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone,
    output armed, ringing, snoozing, buzzer
  );

  modport master (
    output tim_over, hourdec_now, hourone_now, mindec_now, minone_now,
    output set_valid, hourdec_set, hourone_set, mindec_set, minone_set,
    output arm_toggle, stop, snooze,
    input  set_err, alarm_hourdec, alarm_hourone, alarm_mindec, alarm_minone,
    input  armed, ringing, snoozing, buzzer
  );
endinterface

// File: rtl/alarm_ctrl.sv
// Alarm controller sitting behind the watch counter.
// Stores a validated alarm time, detects the first cycle of the matching
// minute, and runs a DISARMED/ARMED/RINGING/SNOOZE state machine that drives
// a square-wave buzzer and LED status flags.
// Ports:
//   clk  - system clock
//   rstn - asynchronous active-low reset
//   bus  - alarm_if.slave: time digits + tim_over tick, set/arm/stop/snooze
//          pulses in; set_err, alarm digits, armed/ringing/snoozing, buzzer out
module alarm_ctrl #(
  parameter int SNOOZE_MIN     = 5,
  parameter int RING_TIMEOUT_S = 60,
  parameter int TONE_DIV       = 25000
) (
  input  logic   clk,
  input  logic   rstn,
  alarm_if.slave bus
);

  localparam int              TONE_W    = $clog2(TONE_DIV);
  localparam logic [7:0]      RING_LAST = 8'(RING_TIMEOUT_S - 1);
  localparam logic [9:0]      SNZ_INIT  = 10'(SNOOZE_MIN * 60 - 1);
  localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_DIV - 1);

  typedef enum logic [1:0] {
    DISARMED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [7:0]          ring_cnt_q, ring_cnt_d;
  logic [9:0]          snz_cnt_q, snz_cnt_d;
  logic [TONE_W-1:0]   tone_cnt_q, tone_cnt_d;
  logic                buzzer_q, buzzer_d;
  logic                match_q;
  logic                set_err_q, set_err_d;
  logic [3:0]          alm_hd_q, alm_ho_q, alm_md_q, alm_mo_q;

  logic match, trigger, set_legal;

  assign match = (bus.hourdec_now == alm_hd_q) && (bus.hourone_now == alm_ho_q) &&
                 (bus.mindec_now  == alm_md_q) && (bus.minone_now  == alm_mo_q);
  // Only the first cycle of a matching minute may start a ring.
  assign trigger = match & ~match_q;

  assign set_legal = (bus.hourdec_set <= 4'd2) && (bus.hourone_set <= 4'd9) &&
                     !((bus.hourdec_set == 4'd2) && (bus.hourone_set > 4'd3)) &&
                     (bus.mindec_set <= 4'd5) && (bus.minone_set <= 4'd9);
  assign set_err_d = bus.set_valid & ~set_legal;

  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    case (state_q)
      DISARMED: begin
        if (bus.arm_toggle) state_d = ARMED;
      end
      ARMED: begin
        if (bus.arm_toggle) begin
          state_d = DISARMED;
        end else if (trigger) begin
          state_d    = RINGING;
          ring_cnt_d = '0;
        end
      end
      RINGING: begin
        if (bus.arm_toggle) begin
          state_d = DISARMED;
        end else if (bus.stop) begin
          state_d = ARMED;
        end else if (bus.snooze) begin
          state_d   = SNOOZE;
          snz_cnt_d = SNZ_INIT;
        end else if (bus.tim_over) begin
          if (ring_cnt_q == RING_LAST) state_d = ARMED;
          else ring_cnt_d = ring_cnt_q + 8'd1;
        end
      end
      SNOOZE: begin
        if (bus.arm_toggle) begin
          state_d = DISARMED;
        end else if (bus.stop) begin
          state_d = ARMED;
        end else if (bus.tim_over) begin
          if (snz_cnt_q == 10'd0) begin
            state_d    = RINGING;
            ring_cnt_d = '0;
          end else begin
            snz_cnt_d = snz_cnt_q - 10'd1;
          end
        end
      end
      default: state_d = DISARMED;
    endcase
  end

  // Tone generator follows the next state so the buzzer turns on together
  // with ringing and drops together with it.
  always_comb begin
    tone_cnt_d = '0;
    buzzer_d   = 1'b0;
    if (state_d == RINGING) begin
      if (state_q != RINGING) begin
        buzzer_d = 1'b1;
      end else if (tone_cnt_q == TONE_LAST) begin
        buzzer_d = ~buzzer_q;
      end else begin
        tone_cnt_d = tone_cnt_q + TONE_W'(1);
        buzzer_d   = buzzer_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= DISARMED;
      ring_cnt_q <= '0;
      snz_cnt_q  <= '0;
      tone_cnt_q <= '0;
      buzzer_q   <= 1'b0;
      match_q    <= 1'b0;
      set_err_q  <= 1'b0;
      alm_hd_q   <= '0;
      alm_ho_q   <= '0;
      alm_md_q   <= '0;
      alm_mo_q   <= '0;
    end else begin
      state_q    <= state_d;
      ring_cnt_q <= ring_cnt_d;
      snz_cnt_q  <= snz_cnt_d;
      tone_cnt_q <= tone_cnt_d;
      buzzer_q   <= buzzer_d;
      match_q    <= match;
      set_err_q  <= set_err_d;
      if (bus.set_valid && set_legal) begin
        alm_hd_q <= bus.hourdec_set;
        alm_ho_q <= bus.hourone_set;
        alm_md_q <= bus.mindec_set;
        alm_mo_q <= bus.minone_set;
      end
    end
  end

  assign bus.set_err       = set_err_q;
  assign bus.alarm_hourdec = alm_hd_q;
  assign bus.alarm_hourone = alm_ho_q;
  assign bus.alarm_mindec  = alm_md_q;
  assign bus.alarm_minone  = alm_mo_q;
  assign bus.armed         = (state_q != DISARMED);
  assign bus.ringing       = (state_q == RINGING);
  assign bus.snoozing      = (state_q == SNOOZE);
  assign bus.buzzer        = buzzer_q;

endmodule

// File: tb/tb_alarm_ctrl.sv
// Testbench for alarm_ctrl: set-legality vector table, directed ring/snooze/
// stop/reset sequences, and randomized traffic against a reference model.
module tb_alarm_ctrl;

  localparam int SNZ = 1;
  localparam int RT  = 5;
  localparam int TD  = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  alarm_if bus ();

  alarm_ctrl #(.SNOOZE_MIN(SNZ), .RING_TIMEOUT_S(RT), .TONE_DIV(TD)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  int checks = 0;
  int failures = 0;
  int tick_cnt = 0;
  bit tick_en = 1'b0;

  // Reference model: alarm behaviour described as flags and remaining counts.
  bit m_armed, m_ring, m_snz, m_buz, m_err, m_prev;
  int m_ring_ticks, m_snz_left, m_age;
  int m_alm[4];

  typedef struct {
    logic [3:0]  hd, ho, md, mo;
    logic        err;
    logic [15:0] alm;
  } set_vec_t;
  set_vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_armed = 0; m_ring = 0; m_snz = 0; m_buz = 0; m_err = 0; m_prev = 0;
    m_ring_ticks = 0; m_snz_left = 0; m_age = 0;
    for (int i = 0; i < 4; i++) m_alm[i] = 0;
  endtask

  task automatic model_update();
    bit match, trig, was_ring, legal;
    int hd, ho, md, mo;
    match = (int'(bus.hourdec_now) == m_alm[0]) && (int'(bus.hourone_now) == m_alm[1]) &&
            (int'(bus.mindec_now) == m_alm[2]) && (int'(bus.minone_now) == m_alm[3]);
    trig = match && !m_prev;
    m_prev = match;
    was_ring = m_ring;
    if (bus.arm_toggle) begin
      if (!m_armed) m_armed = 1;
      else begin m_armed = 0; m_ring = 0; m_snz = 0; end
    end else if (bus.stop && (m_ring || m_snz)) begin
      m_ring = 0; m_snz = 0;
    end else if (bus.snooze && m_ring) begin
      m_ring = 0; m_snz = 1; m_snz_left = SNZ * 60;
    end else if (m_ring) begin
      if (bus.tim_over) begin
        m_ring_ticks++;
        if (m_ring_ticks == RT) m_ring = 0;
      end
    end else if (m_snz) begin
      if (bus.tim_over) begin
        m_snz_left--;
        if (m_snz_left == 0) begin m_snz = 0; m_ring = 1; m_ring_ticks = 0; end
      end
    end else if (m_armed && trig) begin
      m_ring = 1; m_ring_ticks = 0;
    end
    if (m_ring) begin
      if (!was_ring) m_age = 0; else m_age++;
      m_buz = ((m_age / TD) % 2) == 0;
    end else begin
      m_buz = 0;
    end
    m_err = 0;
    if (bus.set_valid) begin
      hd = bus.hourdec_set; ho = bus.hourone_set; md = bus.mindec_set; mo = bus.minone_set;
      legal = (hd <= 2) && (ho <= 9) && (hd != 2 || ho <= 3) && (md <= 5) && (mo <= 9);
      if (legal) begin m_alm[0] = hd; m_alm[1] = ho; m_alm[2] = md; m_alm[3] = mo; end
      else m_err = 1;
    end
  endtask

  task automatic check_all();
    chk("armed", 32'(bus.armed), 32'(m_armed));
    chk("ringing", 32'(bus.ringing), 32'(m_ring));
    chk("snoozing", 32'(bus.snoozing), 32'(m_snz));
    chk("buzzer", 32'(bus.buzzer), 32'(m_buz));
    chk("set_err", 32'(bus.set_err), 32'(m_err));
    chk("alarm_digits",
        32'({bus.alarm_hourdec, bus.alarm_hourone, bus.alarm_mindec, bus.alarm_minone}),
        32'({m_alm[0][3:0], m_alm[1][3:0], m_alm[2][3:0], m_alm[3][3:0]}));
  endtask

  // One clock: model consumes current inputs, DUT samples them, outputs are
  // compared 2 ns after the edge, then pulses clear and the tick is scheduled.
  task automatic step();
    model_update();
    @(posedge clk);
    #2;
    check_all();
    bus.set_valid = 0; bus.arm_toggle = 0; bus.stop = 0; bus.snooze = 0;
    tick_cnt++;
    bus.tim_over = tick_en && (tick_cnt % 10 == 0);
  endtask

  task automatic set_time(input int hh, input int mm);
    bus.hourdec_now = 4'(hh / 10); bus.hourone_now = 4'(hh % 10);
    bus.mindec_now  = 4'(mm / 10); bus.minone_now  = 4'(mm % 10);
  endtask

  task automatic set_alarm(input logic [3:0] hd, ho, md, mo);
    bus.set_valid = 1;
    bus.hourdec_set = hd; bus.hourone_set = ho; bus.mindec_set = md; bus.minone_set = mo;
  endtask

  int ringticks, snzticks;
  bit any_ring;
  int tlist[5][2] = '{'{7, 29}, '{7, 30}, '{12, 0}, '{12, 1}, '{23, 59}};

  initial begin
    tbl[0] = '{4'd2, 4'd3, 4'd5, 4'd9, 1'b0, 16'h2359};
    tbl[1] = '{4'd2, 4'd4, 4'd0, 4'd0, 1'b1, 16'h2359};
    tbl[2] = '{4'd1, 4'd9, 4'd6, 4'd0, 1'b1, 16'h2359};
    tbl[3] = '{4'd1, 4'd9, 4'd5, 4'd9, 1'b0, 16'h1959};
    tbl[4] = '{4'd2, 4'd0, 4'd0, 4'd0, 1'b0, 16'h2000};
    tbl[5] = '{4'd2, 4'd9, 4'd0, 4'd0, 1'b1, 16'h2000};
    tbl[6] = '{4'd3, 4'd0, 4'd0, 4'd0, 1'b1, 16'h2000};
    tbl[7] = '{4'd0, 4'd9, 4'd5, 4'd10, 1'b1, 16'h2000};
    tbl[8] = '{4'd0, 4'd7, 4'd3, 4'd0, 1'b0, 16'h0730};

    bus.tim_over = 0; bus.set_valid = 0; bus.arm_toggle = 0; bus.stop = 0; bus.snooze = 0;
    bus.hourdec_set = 0; bus.hourone_set = 0; bus.mindec_set = 0; bus.minone_set = 0;
    set_time(7, 29);
    m_reset();

    // Reset state
    #22;
    chk("rst_armed", 32'(bus.armed), 32'd0);
    chk("rst_ringing", 32'(bus.ringing), 32'd0);
    chk("rst_buzzer", 32'(bus.buzzer), 32'd0);
    chk("rst_set_err", 32'(bus.set_err), 32'd0);
    chk("rst_alarm", 32'({bus.alarm_hourdec, bus.alarm_hourone, bus.alarm_mindec, bus.alarm_minone}), 32'h0);
    @(posedge clk); #2;
    rstn = 1;
    step();

    // Alarm-load legality table
    foreach (tbl[i]) begin
      set_alarm(tbl[i].hd, tbl[i].ho, tbl[i].md, tbl[i].mo);
      step();
      chk($sformatf("tbl%0d_err", i), 32'(bus.set_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_alm", i),
          32'({bus.alarm_hourdec, bus.alarm_hourone, bus.alarm_mindec, bus.alarm_minone}),
          32'(tbl[i].alm));
      step();
      chk($sformatf("tbl%0d_err_clear", i), 32'(bus.set_err), 32'd0);
    end

    // Arm, trigger at 07:30, buzzer pattern
    tick_en = 1;
    bus.arm_toggle = 1; step();
    chk("arm", 32'(bus.armed), 32'd1);
    set_time(7, 30); step();
    chk("trig_ringing", 32'(bus.ringing), 32'd1);
    chk("trig_buzzer", 32'(bus.buzzer), 32'd1);
    ringticks = 0;
    for (int k = 1; k < 10; k++) begin
      if (bus.tim_over) ringticks++;
      step();
      chk($sformatf("buz_age%0d", k), 32'(bus.buzzer), 32'(((k / TD) % 2) == 0));
    end

    // Ring timeout, no re-ring within the minute
    for (int i = 0; i < 200 && bus.ringing; i++) begin
      if (bus.tim_over) ringticks++;
      step();
    end
    chk("timeout_ticks", 32'(ringticks), 32'(RT));
    chk("timeout_ringing", 32'(bus.ringing), 32'd0);
    chk("timeout_armed", 32'(bus.armed), 32'd1);
    chk("timeout_buzzer", 32'(bus.buzzer), 32'd0);
    any_ring = 0;
    for (int i = 0; i < 40; i++) begin step(); any_ring |= bus.ringing; end
    chk("no_rering", 32'(any_ring), 32'd0);

    // Snooze then re-ring on the 60th tick, stop during second ring
    set_time(7, 31); step();
    set_time(7, 30); step();
    chk("ring2", 32'(bus.ringing), 32'd1);
    bus.snooze = 1; step();
    chk("snooze_flag", 32'(bus.snoozing), 32'd1);
    chk("snooze_buzzer", 32'(bus.buzzer), 32'd0);
    snzticks = 0;
    for (int i = 0; i < 800 && !bus.ringing; i++) begin
      if (bus.tim_over) snzticks++;
      step();
    end
    chk("rering", 32'(bus.ringing), 32'd1);
    chk("rering_ticks", 32'(snzticks), 32'(SNZ * 60));
    step(); step();
    bus.stop = 1; step();
    chk("stop_armed", 32'(bus.armed), 32'd1);
    chk("stop_ringing", 32'(bus.ringing), 32'd0);

    // Stop and snooze together; disarmed match; arm during match
    set_time(7, 31); step();
    set_time(7, 30); step();
    chk("ring3", 32'(bus.ringing), 32'd1);
    bus.stop = 1; bus.snooze = 1; step();
    chk("both_armed", 32'(bus.armed), 32'd1);
    chk("both_snoozing", 32'(bus.snoozing), 32'd0);
    chk("both_ringing", 32'(bus.ringing), 32'd0);
    bus.arm_toggle = 1; step();
    chk("disarm", 32'(bus.armed), 32'd0);
    set_alarm(4'd1, 4'd2, 4'd0, 4'd0); step();
    set_time(12, 0);
    any_ring = 0;
    for (int i = 0; i < 20; i++) begin step(); any_ring |= bus.ringing; end
    chk("disarmed_no_ring", 32'(any_ring), 32'd0);
    bus.arm_toggle = 1; step();
    for (int i = 0; i < 20; i++) begin step(); any_ring |= bus.ringing; end
    chk("arm_in_match_no_ring", 32'(any_ring), 32'd0);
    set_time(12, 1); step();
    set_time(12, 0); step();
    chk("next_match_ring", 32'(bus.ringing), 32'd1);

    // Asynchronous reset mid-ring
    step(); step(); step();
    #1 rstn = 0;
    #1;
    m_reset();
    chk("arst_buzzer", 32'(bus.buzzer), 32'd0);
    chk("arst_ringing", 32'(bus.ringing), 32'd0);
    chk("arst_armed", 32'(bus.armed), 32'd0);
    chk("arst_alarm", 32'({bus.alarm_hourdec, bus.alarm_hourone, bus.alarm_mindec, bus.alarm_minone}), 32'h0);
    @(posedge clk); #2;
    rstn = 1;
    step();

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      int r;
      if ($urandom_range(0, 7) == 0) begin
        r = $urandom_range(0, 4);
        set_time(tlist[r][0], tlist[r][1]);
      end
      bus.arm_toggle = ($urandom_range(0, 59) == 0);
      bus.stop       = ($urandom_range(0, 79) == 0);
      bus.snooze     = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 69) == 0) begin
        if ($urandom_range(0, 2) != 0) begin
          r = $urandom_range(0, 4);
          set_alarm(4'(tlist[r][0] / 10), 4'(tlist[r][0] % 10),
                    4'(tlist[r][1] / 10), 4'(tlist[r][1] % 10));
        end else begin
          set_alarm(4'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
                    4'($urandom_range(0, 7)), 4'($urandom_range(0, 11)));
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
